gb_oam_dma: RTL and testbench

//  OAM DMA controller for the DMG core. CPU write to $FF46 copies 160 bytes from page XX00-XX9F into OAM $FE00-$FE9F.

---
 rtl/gb_dma_pkg.sv | 12 +
 rtl/gb_oam_dma.sv | 139 +++++++++++++
 tb/tb_gb_oam_dma.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_dma_pkg.sv
// gb_dma_pkg: shared state type, register addresses and source page remap for the OAM DMA controller
package gb_dma_pkg;
  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t;
  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
  localparam logic [15:0] HRAM_LO        = 16'hFF80;
  localparam logic [15:0] HRAM_HI        = 16'hFFFE;
  localparam logic [7:0]  ECHO_PAGE_BASE = 8'hE0;
  // Pages $E0-$FF read through the echo of work RAM; every other page passes unchanged
  function automatic logic [7:0] remap_page(input logic [7:0] p);
    return (p >= ECHO_PAGE_BASE) ? {3'b110, p[4:0]} : p;
  endfunction
endpackage

// File: rtl/gb_oam_dma.sv
// gb_oam_dma: OAM DMA engine copying OAM_BYTES bytes from page XX00 into OAM after a $FF46 write
// Ports: clk, reset (synchronous, active-high);
//   cpu_addr/cpu_wr/cpu_di trigger the transfer, cpu_do reads back the last $FF46 value;
//   cpu_blocked suppresses CPU bus accesses; dma_active marks a transfer in progress;
//   src_rd/src_addr/src_data source bus (sync RAM, data valid one clk after src_rd);
//   oam_wr/oam_addr/oam_data OAM write port.
// Build option: GB_DMA_CPU_BLOCK_EN blocks CPU accesses outside $FF00-$FFFF while active.
module gb_oam_dma
  import gb_dma_pkg::*;
#(
  parameter int unsigned OAM_BYTES    = 160,
  parameter int unsigned CYC_PER_BYTE = 4,
  parameter int unsigned START_DELAY  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  output logic        cpu_blocked,
  output logic        dma_active,
  output logic        src_rd,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data
);
  localparam int PW = (CYC_PER_BYTE > 1) ? $clog2(CYC_PER_BYTE) : 1;
  localparam int CW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  dma_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    page_q, page_d;
  logic [7:0]    cpu_do_q, cpu_do_d;
  logic          hit_q, hit_d;
  logic          dma_active_q, dma_active_d;
  logic          src_rd_q, src_rd_d;
  logic [15:0]   src_addr_q, src_addr_d;
  logic          oam_wr_q, oam_wr_d;
  logic [7:0]    oam_addr_q, oam_addr_d;
  logic [7:0]    oam_data_q, oam_data_d;
  logic          trig;

  // A write held over several clk is one trigger: only the rising edge of the decode counts
  assign hit_d = cpu_wr && cpu_addr == DMA_REG_ADDR;
  assign trig  = hit_d && !hit_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    page_d   = page_q;
    cpu_do_d = cpu_do_q;
    // Source data arrives during phase 1 and is held for the phase 2 OAM write
    oam_data_d = (state_q == DMA_XFER && phase_q == PW'(1)) ? src_data : oam_data_q;
    if (state_q == DMA_START) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(START_DELAY - 1)) begin
        state_d = DMA_XFER;
        phase_d = '0;
        idx_d   = '0;
      end
    end else if (state_q == DMA_XFER) begin
      phase_d = phase_q + 1'b1;
      if (phase_q == PW'(CYC_PER_BYTE - 1)) begin
        phase_d = '0;
        idx_d   = idx_q + 1'b1;
        if (idx_q == 8'(OAM_BYTES - 1)) state_d = DMA_IDLE;
      end
    end
    // A trigger restarts from any state; an aborted byte never reaches its write phase
    if (trig) begin
      state_d  = DMA_START;
      cnt_d    = '0;
      phase_d  = '0;
      idx_d    = '0;
      page_d   = remap_page(cpu_di);
      cpu_do_d = cpu_di;
    end
    // Outputs are registered from the next state so they line up with the state they describe
    dma_active_d = state_d != DMA_IDLE;
    src_rd_d     = state_d == DMA_XFER && phase_d == '0;
    src_addr_d   = src_rd_d ? {page_d, idx_d} : src_addr_q;
    oam_wr_d     = state_d == DMA_XFER && phase_d == PW'(2);
    oam_addr_d   = oam_wr_d ? idx_d : oam_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DMA_IDLE;
      cnt_q        <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      page_q       <= '0;
      cpu_do_q     <= '0;
      hit_q        <= 1'b0;
      dma_active_q <= 1'b0;
      src_rd_q     <= 1'b0;
      src_addr_q   <= '0;
      oam_wr_q     <= 1'b0;
      oam_addr_q   <= '0;
      oam_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      page_q       <= page_d;
      cpu_do_q     <= cpu_do_d;
      hit_q        <= hit_d;
      dma_active_q <= dma_active_d;
      src_rd_q     <= src_rd_d;
      src_addr_q   <= src_addr_d;
      oam_wr_q     <= oam_wr_d;
      oam_addr_q   <= oam_addr_d;
      oam_data_q   <= oam_data_d;
    end
  end

  assign cpu_do     = cpu_do_q;
  assign dma_active = dma_active_q;
  assign src_rd     = src_rd_q;
  assign src_addr   = src_addr_q;
  assign oam_wr     = oam_wr_q;
  assign oam_addr   = oam_addr_q;
  assign oam_data   = oam_data_q;

`ifdef GB_DMA_CPU_BLOCK_EN
  assign cpu_blocked = dma_active_q && !(cpu_addr >= HRAM_LO && cpu_addr <= HRAM_HI) &&
                       cpu_addr[15:8] != 8'hFF;
`else
  assign cpu_blocked = 1'b0;
`endif
endmodule

// File: tb/tb_gb_oam_dma.sv
// tb_gb_oam_dma: randomized self-checking bench for gb_oam_dma against a transfer-level model
module tb_gb_oam_dma;
  localparam int N = 160;
  localparam int CPB = 4;
  localparam int SD = 4;
  localparam int TOTAL = SD + N * CPB;
`ifdef GB_DMA_CPU_BLOCK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] c;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_di = 8'h00;
  logic [7:0]  src_data = 8'h00;
  logic [7:0]  salt = 8'h00;
  logic [7:0]  cpu_do, oam_addr, oam_data;
  logic        cpu_blocked, dma_active, src_rd, oam_wr;
  logic [15:0] src_addr;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          both_cnt = 0;
  int          idle_viol = 0;
  ev_t         rd_q[$], wr_q[$], exp_rd[$], exp_wr[$];

  gb_oam_dma dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_blocked(cpu_blocked), .dma_active(dma_active), .src_rd(src_rd),
    .src_addr(src_addr), .src_data(src_data), .oam_wr(oam_wr), .oam_addr(oam_addr),
    .oam_data(oam_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous source memory: contents depend on both address bytes and a per-test salt
  always @(posedge clk) if (src_rd) src_data <= src_addr[7:0] ^ src_addr[15:8] ^ salt;

  always @(negedge clk) begin
    if (!reset) begin
      if (src_rd) rd_q.push_back(ev_t'{c: 32'(cyc), a: src_addr, d: 8'h00});
      if (oam_wr) wr_q.push_back(ev_t'{c: 32'(cyc), a: {8'h00, oam_addr}, d: oam_data});
      if (src_rd && oam_wr) both_cnt++;
      if ((src_rd || oam_wr) && !dma_active) idle_viol++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [7:0] eff_page(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  // Transfer triggered at edge t: byte k is read at t+SD+CPB*k and written two clk later
  function automatic void build_exp(input int t, input logic [7:0] p, input int n);
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back(ev_t'{c: 32'(t + SD + CPB * k), a: {eff_page(p), 8'(k)}, d: 8'h00});
      exp_wr.push_back(ev_t'{c: 32'(t + SD + CPB * k + 2), a: 16'(k), d: 8'(k) ^ eff_page(p) ^ salt});
    end
  endfunction

  task automatic cpu_write(input logic [7:0] v, input int hold, output int t);
    @(posedge clk); #1;
    cpu_addr = 16'hFF46; cpu_wr = 1'b1; cpu_di = v; t = cyc + 1;
    repeat (hold) @(posedge clk);
    #1;
    cpu_wr = 1'b0; cpu_addr = 16'h1234; cpu_di = 8'($urandom);
  endtask

  task automatic wait_idle(output int te);
    te = -1;
    for (int n = 0; n < 2000 && te < 0; n++) begin
      @(negedge clk);
      if (!dma_active) te = cyc;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_do !== 8'h00) begin failures++; $display("FAIL reset_cpu_do got %h want 00", cpu_do); end
    checks++; if (dma_active !== 1'b0) begin failures++; $display("FAIL reset_active got %b want 0", dma_active); end
    checks++; if (src_rd !== 1'b0) begin failures++; $display("FAIL reset_src_rd got %b want 0", src_rd); end
    checks++; if (oam_wr !== 1'b0) begin failures++; $display("FAIL reset_oam_wr got %b want 0", oam_wr); end
    checks++; if (cpu_blocked !== 1'b0) begin failures++; $display("FAIL reset_blocked got %b want 0", cpu_blocked); end
    checks++; if (src_addr !== 16'h0000) begin failures++; $display("FAIL reset_src_addr got %h want 0000", src_addr); end
    checks++; if (oam_addr !== 8'h00) begin failures++; $display("FAIL reset_oam_addr got %h want 00", oam_addr); end
    checks++; if (oam_data !== 8'h00) begin failures++; $display("FAIL reset_oam_data got %h want 00", oam_data); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_pages();
    logic [7:0] pages [4];
    int t, te, r0, w0;
    pages = '{8'hC0, 8'hE1, 8'($urandom), 8'($urandom_range(224, 255))};
    for (int j = 0; j < 4; j++) begin
      salt = (j == 0) ? 8'hC0 : 8'($urandom);
      exp_rd.delete(); exp_wr.delete();
      r0 = rd_q.size(); w0 = wr_q.size();
      cpu_write(pages[j], 1, t);
      build_exp(t, pages[j], N);
      wait_idle(te);
      checks++; if (te !== t + TOTAL) begin failures++; $display("FAIL pages%0d_length got %0d want %0d", j, te - t, TOTAL); end
      checks++; if (cpu_do !== pages[j]) begin failures++; $display("FAIL pages%0d_cpu_do got %h want %h", j, cpu_do, pages[j]); end
      checks++;
      if (rd_q.size() - r0 != exp_rd.size() || wr_q.size() - w0 != exp_wr.size()) begin
        failures++;
        $display("FAIL pages%0d_count rd=%0d wr=%0d want %0d/%0d", j, rd_q.size() - r0, wr_q.size() - w0, exp_rd.size(), exp_wr.size());
      end else begin
        for (int i = 0; i < exp_rd.size(); i++) begin
          checks++;
          if (rd_q[r0 + i] !== exp_rd[i]) begin failures++; $display("FAIL pages%0d_rd[%0d] got c=%0d a=%h want c=%0d a=%h", j, i, rd_q[r0 + i].c, rd_q[r0 + i].a, exp_rd[i].c, exp_rd[i].a); break; end
        end
        for (int i = 0; i < exp_wr.size(); i++) begin
          checks++;
          if (wr_q[w0 + i] !== exp_wr[i]) begin failures++; $display("FAIL pages%0d_wr[%0d] got c=%0d a=%h d=%h want c=%0d a=%h d=%h", j, i, wr_q[w0 + i].c, wr_q[w0 + i].a, wr_q[w0 + i].d, exp_wr[i].c, exp_wr[i].a, exp_wr[i].d); break; end
        end
      end
    end
  endtask

  // retrigger_at: cycle offset after the first trigger at which the second trigger is sampled
  task automatic test_retrigger(input string nm, input int retrigger_at, input int old_rd, input int old_wr);
    int t, t2, te, r0, w0;
    logic [7:0] p1, p2;
    p1 = 8'($urandom); p2 = (nm == "retrig50") ? 8'h80 : 8'($urandom);
    salt = 8'($urandom);
    exp_rd.delete(); exp_wr.delete();
    r0 = rd_q.size(); w0 = wr_q.size();
    cpu_write(p1, 1, t);
    wait_cyc(t + retrigger_at - 2);
    cpu_write(p2, 1, t2);
    build_exp(t, p1, old_rd);
    while (exp_wr.size() > old_wr) void'(exp_wr.pop_back());
    build_exp(t2, p2, N);
    wait_idle(te);
    checks++; if (t2 !== t + retrigger_at) begin failures++; $display("FAIL %s_align got %0d want %0d", nm, t2 - t, retrigger_at); end
    checks++; if (te !== t2 + TOTAL) begin failures++; $display("FAIL %s_active got low at +%0d want +%0d", nm, te - t, retrigger_at + TOTAL); end
    checks++; if (cpu_do !== p2) begin failures++; $display("FAIL %s_cpu_do got %h want %h", nm, cpu_do, p2); end
    checks++;
    if (rd_q.size() - r0 != exp_rd.size() || wr_q.size() - w0 != exp_wr.size()) begin
      failures++;
      $display("FAIL %s_count rd=%0d wr=%0d want %0d/%0d", nm, rd_q.size() - r0, wr_q.size() - w0, exp_rd.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_rd.size(); i++) begin
        checks++;
        if (rd_q[r0 + i] !== exp_rd[i]) begin failures++; $display("FAIL %s_rd[%0d] got c=%0d a=%h want c=%0d a=%h", nm, i, rd_q[r0 + i].c - t, rd_q[r0 + i].a, exp_rd[i].c - t, exp_rd[i].a); break; end
      end
      for (int i = 0; i < exp_wr.size(); i++) begin
        checks++;
        if (wr_q[w0 + i] !== exp_wr[i]) begin failures++; $display("FAIL %s_wr[%0d] got c=%0d a=%h d=%h want c=%0d a=%h d=%h", nm, i, wr_q[w0 + i].c - t, wr_q[w0 + i].a, wr_q[w0 + i].d, exp_wr[i].c - t, exp_wr[i].a, exp_wr[i].d); break; end
      end
    end
  endtask

  task automatic test_hold();
    int t, te, r0, w0;
    logic [7:0] p;
    p = 8'($urandom); salt = 8'($urandom);
    exp_rd.delete(); exp_wr.delete();
    r0 = rd_q.size(); w0 = wr_q.size();
    cpu_write(p, 3, t);
    build_exp(t, p, N);
    wait_idle(te);
    checks++; if (te !== t + TOTAL) begin failures++; $display("FAIL hold_length got %0d want %0d", te - t, TOTAL); end
    checks++;
    if (rd_q.size() - r0 != exp_rd.size() || wr_q.size() - w0 != exp_wr.size()) begin
      failures++;
      $display("FAIL hold_count rd=%0d wr=%0d want %0d/%0d", rd_q.size() - r0, wr_q.size() - w0, exp_rd.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        checks++;
        if (wr_q[w0 + i] !== exp_wr[i] || rd_q[r0 + i] !== exp_rd[i]) begin failures++; $display("FAIL hold_byte[%0d] got wr c=%0d d=%h rd a=%h want wr c=%0d d=%h rd a=%h", i, wr_q[w0 + i].c - t, wr_q[w0 + i].d, rd_q[r0 + i].a, exp_wr[i].c - t, exp_wr[i].d, exp_rd[i].a); break; end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, r0, w0;
    salt = 8'($urandom);
    w0 = wr_q.size();
    cpu_write(8'($urandom), 1, t);
    wait_cyc(t + SD + CPB * 10 - 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (wr_q.size() - w0 !== 10) begin failures++; $display("FAIL rstmid_written got %0d want 10", wr_q.size() - w0); end
    checks++; if (dma_active !== 1'b0 || src_rd !== 1'b0 || oam_wr !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got act=%b rd=%b wr=%b want 000", dma_active, src_rd, oam_wr); end
    checks++; if (src_addr !== 16'h0000 || oam_addr !== 8'h00 || oam_data !== 8'h00 || cpu_do !== 8'h00) begin failures++; $display("FAIL rstmid_data got sa=%h oa=%h od=%h do=%h want zeros", src_addr, oam_addr, oam_data, cpu_do); end
    checks++; if (cpu_blocked !== 1'b0) begin failures++; $display("FAIL rstmid_blocked got %b want 0", cpu_blocked); end
    @(posedge clk); #1;
    reset = 1'b0;
    r0 = rd_q.size(); w0 = wr_q.size();
    repeat (100) @(negedge clk);
    checks++; if (rd_q.size() != r0 || wr_q.size() != w0 || dma_active !== 1'b0) begin failures++; $display("FAIL rstmid_quiet got rd=%0d wr=%0d act=%b want 0 0 0", rd_q.size() - r0, wr_q.size() - w0, dma_active); end
  endtask

  task automatic test_block();
    int t, te;
    logic [15:0] a;
    logic exp_b;
    salt = 8'($urandom);
    cpu_write(8'($urandom), 1, t);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 3))
        0: a = 16'hFF85;
        1: a = 16'hC000;
        2: a = {8'hFF, 8'($urandom)};
        default: a = 16'($urandom);
      endcase
      cpu_addr = a;
      @(negedge clk);
      exp_b = BLK && a < 16'hFF00;
      checks++; if (cpu_blocked !== exp_b) begin failures++; $display("FAIL block_%h got %b want %b", a, cpu_blocked, exp_b); end
    end
    wait_idle(te);
    checks++; if (te !== t + TOTAL) begin failures++; $display("FAIL block_length got %0d want %0d", te - t, TOTAL); end
    cpu_addr = 16'hC000;
    #1;
    checks++; if (cpu_blocked !== 1'b0) begin failures++; $display("FAIL block_idle got %b want 0", cpu_blocked); end
  endtask

  initial begin
    test_reset();
    test_pages();
    test_retrigger("retrig50", SD + CPB * 50 + 1, 51, 50);
    test_hold();
    test_retrigger("retrig_last", SD + CPB * (N - 1) + 3, N, N);
    test_reset_mid();
    test_block();
    checks++; if (both_cnt !== 0 || idle_viol !== 0) begin failures++; $display("FAIL strobes got both=%0d idle=%0d want 0 0", both_cnt, idle_viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
